// File: rtl/csel8_sync_launcher.sv
// Clocked launch stage for the 8-way conditional-fork selector: holds a one-hot valid,
// issues the drive pulse, and tracks synchronized fire/free events to completion or timeout.
module csel8_sync_launcher #(
    parameter int unsigned DRIVE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_idx,
    output logic       done_valid,
    output logic [2:0] done_idx,
    output logic       timeout_err,
    output logic       o_drive,
    output logic [7:0] o_valid,
    input  logic       i_fire,
    input  logic [7:0] i_free_tgt
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DRIVE,
        WAIT_FIRE,
        WAIT_DONE,
        COMPLETE
    } state_t;

    localparam int unsigned DW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;
    localparam logic [DW-1:0]    DRIVE_LAST = DW'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       idx_q;
    logic [DW-1:0]    drive_cnt, drive_cnt_nxt;
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
    logic             fire_seen, fire_seen_nxt;
    logic             free_seen, free_seen_nxt;
    logic             rst_done;
    logic             accept;
    logic             tmo_abort;

    logic             fire_s1, fire_s2, fire_prev;
    logic [7:0]       free_s1, free_s2, free_prev;
    logic             fire_ev;
    logic             free_hit;
    logic             tmo_hit;

    // The previous-value flops follow the synchronized levels every cycle, so on entry
    // to SETUP they already hold the current levels and a stale high input cannot fire.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire_s1   <= 1'b0;
            fire_s2   <= 1'b0;
            fire_prev <= 1'b0;
            free_s1   <= '0;
            free_s2   <= '0;
            free_prev <= '0;
        end else begin
            fire_s1   <= i_fire;
            fire_s2   <= fire_s1;
            fire_prev <= fire_s2;
            free_s1   <= i_free_tgt;
            free_s2   <= free_s1;
            free_prev <= free_s2;
        end
    end

    assign fire_ev  = fire_s2 & ~fire_prev;
    assign free_hit = free_s2[idx_q] & ~free_prev[idx_q];
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    assign req_ready  = rst_done && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign o_drive    = (state == DRIVE);
    assign done_valid = (state == COMPLETE);
    assign done_idx   = done_valid ? idx_q : '0;

    always_comb begin
        state_nxt     = state;
        drive_cnt_nxt = drive_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        fire_seen_nxt = fire_seen;
        free_seen_nxt = free_seen;
        tmo_abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                drive_cnt_nxt = '0;
                fire_seen_nxt = 1'b0;
                free_seen_nxt = 1'b0;
                state_nxt     = DRIVE;
            end
            DRIVE: begin
                if (fire_ev) fire_seen_nxt = 1'b1;
                // A free that lands after (or with) an early fire must not be lost.
                if (free_hit && (fire_seen || fire_ev)) free_seen_nxt = 1'b1;
                if (drive_cnt == DRIVE_LAST) begin
                    tmo_cnt_nxt = '0;
                    if (free_seen_nxt)      state_nxt = COMPLETE;
                    else if (fire_seen_nxt) state_nxt = WAIT_DONE;
                    else                    state_nxt = WAIT_FIRE;
                end else begin
                    drive_cnt_nxt = drive_cnt + 1'b1;
                end
            end
            WAIT_FIRE: begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
                if (fire_ev && free_hit) begin
                    state_nxt = COMPLETE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    tmo_abort = 1'b1;
                end else if (fire_ev) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
                if (free_hit) begin
                    state_nxt = COMPLETE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                    tmo_abort = 1'b1;
                end
            end
            COMPLETE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            idx_q       <= '0;
            drive_cnt   <= '0;
            tmo_cnt     <= '0;
            fire_seen   <= 1'b0;
            free_seen   <= 1'b0;
            o_valid     <= '0;
            timeout_err <= 1'b0;
            rst_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            drive_cnt   <= drive_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            fire_seen   <= fire_seen_nxt;
            free_seen   <= free_seen_nxt;
            timeout_err <= tmo_abort;
            rst_done    <= 1'b1;
            if (accept) begin
                idx_q   <= req_idx;
                o_valid <= 8'd1 << req_idx;
            end else if ((state == COMPLETE) || tmo_abort) begin
                o_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_csel8_sync_launcher.sv
// Bench for csel8_sync_launcher: directed and random transactions checked every cycle
// against a transaction-level timing model.
module tb_csel8_sync_launcher;

    localparam int DRV = 4;
    localparam int TMO = 1023;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_idx;
    logic       done_valid;
    logic [2:0] done_idx;
    logic       timeout_err;
    logic       o_drive;
    logic [7:0] o_valid;
    logic       i_fire;
    logic [7:0] i_free_tgt;

    int total = 0;
    int bad   = 0;

    csel8_sync_launcher #(
        .DRIVE_CYCLES  (DRV),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (10)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idx    (req_idx),
        .done_valid (done_valid),
        .done_idx   (done_idx),
        .timeout_err(timeout_err),
        .o_drive    (o_drive),
        .o_valid    (o_valid),
        .i_fire     (i_fire),
        .i_free_tgt (i_free_tgt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_drive"}, o_drive, 0);
        chk({tag, "_done"}, done_valid, 0);
        chk({tag, "_didx"}, done_idx, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_done", done_valid, 0);
            chk("idle_tmo", timeout_err, 0);
            chk("idle_valid", o_valid, 0);
            chk("idle_ready", req_ready, 1);
        end
    endtask

    // Offsets are cycles after the accept cycle (0). An input raised at offset t becomes
    // an event at t+2; DRIVE spans 2..5 and waiting starts at 6. A free on the chosen
    // target completes if it is not earlier than the fire and lands by the last wait cycle.
    task automatic run_txn(input int idx, input int tf, input int tg, input int wi,
                           input int tw, input int spur, input int abort_at,
                           input bit leave_high);
        int guard;
        int w;
        int f;
        int g;
        int c_end;
        bit done_exp;
        logic [7:0] one;
        logic [7:0] exp_valid;
        guard = 0;
        while (!req_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", req_ready, 1);
        w = 2 + DRV;
        done_exp = 1'b0;
        c_end = w + TMO;
        one = 8'd1 << idx;
        if (tf >= 0 && tg >= 0) begin
            f = tf + 2;
            g = tg + 2;
            if (g >= f && g <= w + TMO - 1) begin
                done_exp = 1'b1;
                c_end = (g + 1 > w) ? g + 1 : w;
            end
        end
        req_valid = 1'b1;
        req_idx = idx[2:0];
        for (int n = 0; n <= c_end + 1; n++) begin
            if (n > 0) begin
                @(negedge clk);
                exp_valid = (done_exp ? (n <= c_end) : (n < c_end)) ? one : 8'd0;
                chk("drive", o_drive, (n >= 2 && n <= w - 1));
                chk("valid", o_valid, exp_valid);
                chk("done", done_valid, (done_exp && n == c_end));
                chk("done_idx", done_idx, (done_exp && n == c_end) ? idx : 0);
                chk("timeout", timeout_err, (!done_exp && n == c_end));
                chk("ready", req_ready, done_exp ? (n > c_end) : (n >= c_end));
            end
            if (n == abort_at) begin
                rstn = 1'b0;
                #1;
                chk_all_zero("abort");
                @(negedge clk);
                i_fire = 1'b0;
                i_free_tgt = '0;
                rstn = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("abort_done", done_valid, 0);
                    chk("abort_tmo", timeout_err, 0);
                end
                return;
            end
            if (n == 1) req_valid = 1'b0;
            if (n == tf) i_fire = 1'b1;
            if (n == spur) i_free_tgt[idx] = 1'b1;
            if (n == spur + 2 && spur >= 0) i_free_tgt[idx] = 1'b0;
            if (n == tg) i_free_tgt[idx] = 1'b1;
            if (wi != idx && n == tw) i_free_tgt[wi] = 1'b1;
            if (wi != idx && tw >= 0 && n == tw + 2) i_free_tgt[wi] = 1'b0;
        end
        if (!leave_high) begin
            i_fire = 1'b0;
            i_free_tgt = '0;
        end
        idle_check(4);
    endtask

    initial begin
        int idx;
        int tf;
        int tg;
        int wi;
        int tw;
        int spur;
        rstn = 1'b0;
        req_valid = 1'b0;
        req_idx = '0;
        i_fire = 1'b1;
        i_free_tgt = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        #1;
        chk("ready_pre", req_ready, 0);
        @(negedge clk);
        chk("ready_post", req_ready, 1);
        i_fire = 1'b0;
        repeat (4) @(negedge clk);

        run_txn(5, 9, 15, 0, -1, -1, -1, 1'b0);       // fire after drive, free later
        run_txn(5, 3, 10, 0, -1, -1, -1, 1'b0);       // early fire during DRIVE
        run_txn(2, 5, 20, 3, 12, -1, -1, 1'b0);       // wrong target first
        run_txn(0, 6, 6, 1, 3, 1, -1, 1'b0);          // spurious free, same-cycle fire/free
        run_txn(7, -1, -1, 0, -1, -1, -1, 1'b0);      // timeout, no fire
        run_txn(1, 1, 1026, 0, -1, -1, -1, 1'b0);     // free on last wait cycle wins
        run_txn(6, 1, 1027, 0, -1, -1, -1, 1'b0);     // free one cycle late -> timeout
        run_txn(4, 2, 6, 0, -1, -1, -1, 1'b1);        // leave inputs high
        run_txn(4, -1, -1, 0, -1, -1, -1, 1'b0);      // stale levels must not complete
        run_txn(3, 1, 30, 0, -1, -1, 10, 1'b0);       // reset in WAIT_DONE
        run_txn(3, 2, 8, 0, -1, -1, -1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            idx = $urandom_range(0, 7);
            tf = $urandom_range(1, 15);
            tg = tf + $urandom_range(0, 12);
            wi = $urandom_range(0, 7);
            tw = (wi != idx) ? $urandom_range(0, tg + 2) : -1;
            spur = (tf >= 5 && $urandom_range(0, 1) == 1) ? $urandom_range(0, tf - 4) : -1;
            run_txn(idx, tf, tg, wi, tw, spur, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
